sqrt_pipe_arbiter: RTL and testbench

//  Shares one fully pipelined integer square-root core between NUM_REQ requesters.

---
 rtl/sqrt_arb_pkg.sv | 20 ++
 rtl/sqrt_pipe_arbiter_rr_arbiter.sv | 35 +++
 rtl/sqrt_pipe_arbiter.sv | 130 +++++++++++++
 tb/tb_sqrt_pipe_arbiter.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared defaults, ID-width helper and tag record for the square-root front-end arbiter.
package sqrt_arb_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_REQ_DEF    = 4;
    localparam int SQRT_LAT_DEF   = 9;

    // A single requester still needs one ID bit so vectors never collapse to zero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(NUM_REQ_DEF);

    typedef struct packed {
        logic                vld;
        logic [ID_W_DEF-1:0] id;
    } tag_t;

endpackage

// File: rtl/sqrt_pipe_arbiter_rr_arbiter.sv
// Rotating-priority search: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[ID_W'(idx)]) begin
                found                 = 1'b1;
                grant[ID_W'(idx)]     = 1'b1;
                grant_id              = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sqrt_pipe_arbiter.sv
// Round-robin front-end sharing one pipelined sqrt core; tags track validity and owner.
// Define SQRT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sqrt_pipe_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int SQRT_LAT   = SQRT_LAT_DEF,
    localparam int ID_W       = id_width(NUM_REQ),
    localparam int RES_W      = DATA_WIDTH / 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_arg,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          sq_arg_vld,
    output logic [DATA_WIDTH-1:0]         sq_arg,
    input  logic [RES_W-1:0]              sq_res,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [RES_W-1:0]              rsp_res,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          busy
);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } arb_tag_t;

    logic [DATA_WIDTH-1:0] arg_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       ptr;
    logic                  issue;

    arb_tag_t              tag_reg [SQRT_LAT];
    arb_tag_t              tail;
    logic                  any_tag_vld;

    logic [NUM_REQ-1:0]    rsp_vld_reg;
    logic [RES_W-1:0]      rsp_res_reg;
    logic [ID_W-1:0]       rsp_id_reg;
    logic                  busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_arg_unpack
            assign arg_arr[gi] = req_arg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req_vld),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // The core never stalls, so any valid request issues in the same cycle.
    assign issue      = |req_vld;
    assign req_rdy    = grant;
    assign sq_arg_vld = issue;
    assign sq_arg     = issue ? arg_arr[grant_id] : '0;

`ifdef SQRT_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] ptr_reg;

    // Idle cycles leave the pointer alone so fairness carries across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (issue) begin
            ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    assign ptr = ptr_reg;
`endif

    assign tail = tag_reg[SQRT_LAT-1];

    always_comb begin
        any_tag_vld = 1'b0;
        for (int i = 0; i < SQRT_LAT; i++) begin
            any_tag_vld = any_tag_vld | tag_reg[i].vld;
        end
    end

    // Tags walk alongside the core's data; clearing them on reset discards in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SQRT_LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= arb_tag_t'{vld: issue, id: grant_id};
            for (int i = 1; i < SQRT_LAT; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_reg <= '0;
            rsp_res_reg <= '0;
            rsp_id_reg  <= '0;
            busy_reg    <= 1'b0;
        end else begin
            busy_reg <= any_tag_vld;
            if (tail.vld) begin
                rsp_vld_reg <= NUM_REQ'(1) << tail.id;
                rsp_res_reg <= sq_res;
                rsp_id_reg  <= tail.id;
            end else begin
                rsp_vld_reg <= '0;
            end
        end
    end

    assign rsp_vld = rsp_vld_reg;
    assign rsp_res = rsp_res_reg;
    assign rsp_id  = rsp_id_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_sqrt_pipe_arbiter.sv
// Bench for sqrt_pipe_arbiter: behavioural sqrt core, scoreboard monitor and directed scenarios.
module tb_sqrt_pipe_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int LAT = 9;
    localparam int RW  = DW / 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*DW-1:0]  req_arg = '0;
    logic [NR-1:0]     req_rdy;
    logic              sq_arg_vld;
    logic [DW-1:0]     sq_arg;
    logic [RW-1:0]     sq_res;
    logic [NR-1:0]     rsp_vld;
    logic [RW-1:0]     rsp_res;
    logic [1:0]        rsp_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sqrt_pipe_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .SQRT_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_arg    (req_arg),
        .req_rdy    (req_rdy),
        .sq_arg_vld (sq_arg_vld),
        .sq_arg     (sq_arg),
        .sq_res     (sq_res),
        .rsp_vld    (rsp_vld),
        .rsp_res    (rsp_res),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    function automatic logic [3:0] isqrt8(input logic [7:0] a);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        return 4'(r);
    endfunction

    // Behavioural core: result of the argument presented LAT cycles earlier, no reset.
    logic [DW-1:0] core_pipe [LAT];
    initial foreach (core_pipe[i]) core_pipe[i] = '0;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= sq_arg;
    end
    assign sq_res = isqrt8(core_pipe[LAT-1]);

    // Scoreboard: expected responses in issue order, plus issue times for busy.
    typedef struct {
        int due;
        int id;
        int res;
    } exp_t;

    exp_t exp_q[$];
    int   issue_q[$];
    int   model_ptr = 0;

    always @(negedge clk) begin
        int            g;
        int            idx;
        logic [NR-1:0] eg;
        logic [DW-1:0] ea;
        logic          eb;
        if (!rst_n) begin
            exp_q.delete();
            issue_q.delete();
            model_ptr = 0;
            n_checks++;
            if (rsp_vld !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL in_reset: rsp_vld=%b busy=%b, required 0000/0", rsp_vld, busy);
            end
        end else begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (model_ptr + k) % NR;
                if (g < 0 && req_vld[idx]) g = idx;
            end
            eg = '0;
            ea = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ea    = req_arg[g*DW +: DW];
            end
            n_checks++;
            if (req_rdy !== eg) begin
                n_fail++;
                $display("FAIL grant cycle %0d: req_rdy=%b required %b (req_vld=%b)", cyc, req_rdy, eg, req_vld);
            end
            n_checks++;
            if (sq_arg_vld !== (g >= 0) || sq_arg !== ea) begin
                n_fail++;
                $display("FAIL issue cycle %0d: sq_arg_vld=%b sq_arg=%0d required %b/%0d", cyc, sq_arg_vld, sq_arg, (g >= 0), ea);
            end
            if (g >= 0) begin
                exp_q.push_back('{cyc + LAT + 1, g, int'(isqrt8(ea))});
                issue_q.push_back(cyc);
`ifndef SQRT_ARB_FIXED_PRIO_EN
                model_ptr = (g + 1) % NR;
`endif
            end

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                eg = '0;
                eg[exp_q[0].id] = 1'b1;
                n_checks++;
                if (rsp_vld !== eg || int'(rsp_res) != exp_q[0].res || int'(rsp_id) != exp_q[0].id) begin
                    n_fail++;
                    $display("FAIL response cycle %0d: rsp_vld=%b res=%0d id=%0d required %b/%0d/%0d",
                             cyc, rsp_vld, rsp_res, rsp_id, eg, exp_q[0].res, exp_q[0].id);
                end else begin
                    $display("rsp cycle %0d id=%0d res=%0d", cyc, rsp_id, rsp_res);
                end
                void'(exp_q.pop_front());
            end else begin
                n_checks++;
                if (rsp_vld !== 4'b0) begin
                    n_fail++;
                    $display("FAIL spurious_rsp cycle %0d: rsp_vld=%b required 0000", cyc, rsp_vld);
                end
            end

            while (issue_q.size() > 0 && issue_q[0] < cyc - LAT - 1) void'(issue_q.pop_front());
            eb = 1'b0;
            foreach (issue_q[i]) if (issue_q[i] <= cyc - 2) eb = 1'b1;
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL busy cycle %0d: busy=%b required %b", cyc, busy, eb);
            end
        end
    end

    task automatic apply_reset();
        rst_n   = 1'b0;
        req_vld = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req_vld = '0;
        req_arg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0 || sq_arg_vld !== 1'b0 || sq_arg !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_issue: req_rdy=%b sq_arg_vld=%b sq_arg=%0d required 0", req_rdy, sq_arg_vld, sq_arg);
        end
        n_checks++;
        if (rsp_vld !== 4'b0 || rsp_res !== 4'd0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: rsp_vld=%b res=%0d id=%0d busy=%b required 0", rsp_vld, rsp_res, rsp_id, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        lat = -1;
        req_vld = 4'b0001;
        req_arg = '0;
        req_arg[7:0] = 8'd144;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: req_rdy=%b required 0001", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 10) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles required 10", lat);
        end
        n_checks++;
        if (rsp_vld !== 4'b0001 || rsp_res !== 4'd12 || rsp_id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rsp: rsp_vld=%b res=%0d id=%0d busy=%b required 0001/12/0/1", rsp_vld, rsp_res, rsp_id, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_vld !== 4'b0) begin
            n_fail++;
            $display("FAIL single_after: busy=%b rsp_vld=%b required 0/0000", busy, rsp_vld);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g [5];
        int            exp_r [5];
        int            exp_i [5];
        logic [NR-1:0] rv [8];
        int            rr [8];
        int            ri [8];
        int            rc [8];
        int            n;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_r = '{15, 10, 7, 0, 15};
        exp_i = '{0, 1, 2, 3, 0};
        apply_reset();
        req_vld = 4'b1111;
        req_arg = {8'd0, 8'd49, 8'd100, 8'd255};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_rdy !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: req_rdy=%b required %b", i, req_rdy, exp_g[i]);
            end
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0 && n < 8) begin
                rv[n] = rsp_vld; rr[n] = int'(rsp_res); ri[n] = int'(rsp_id); rc[n] = cyc;
                n++;
            end
        end
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d responses required 5", n);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            n_checks++;
            if (rr[i] != exp_r[i] || ri[i] != exp_i[i] || rv[i] !== exp_g[i] || rc[i] != rc[0] + i) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: res=%0d id=%0d vld=%b cyc_off=%0d required %0d/%0d/%b/%0d",
                         i, rr[i], ri[i], rv[i], rc[i] - rc[0], exp_r[i], exp_i[i], exp_g[i], i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [7:0] args [3];
        int         exp_r [3];
        int         rr [8];
        int         rc [8];
        int         n;
        int         bad;
        args  = '{8'd225, 8'd16, 8'd1};
        exp_r = '{15, 4, 1};
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            req_vld = 4'b0100;
            req_arg[16 +: 8] = args[i];
            @(negedge clk);
            n_checks++;
            if (req_rdy !== 4'b0100) begin
                n_fail++;
                $display("FAIL stream_grant[%0d]: req_rdy=%b required 0100", i, req_rdy);
            end
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0 && n < 8) begin
                if (rsp_vld !== 4'b0100) bad++;
                rr[n] = int'(rsp_res); rc[n] = cyc;
                n++;
            end
        end
        n_checks++;
        if (n != 3 || bad != 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d pulses (%0d not 0100) required 3", n, bad);
        end
        for (int i = 0; i < 3 && i < n; i++) begin
            n_checks++;
            if (rr[i] != exp_r[i] || rc[i] != rc[0] + i) begin
                n_fail++;
                $display("FAIL stream_rsp[%0d]: res=%0d cyc_off=%0d required %0d/%0d", i, rr[i], rc[i] - rc[0], exp_r[i], i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        int         spurious;
        int         lat;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            req_vld = 4'b0010;
            req_arg[8 +: 8] = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b0;
        req_vld = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_vld !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_hold[%0d]: rsp_vld=%b busy=%b required 0000/0", k, rsp_vld, busy);
            end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0 || busy !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: %0d cycles with rsp/busy, required 0", spurious);
        end
        @(posedge clk);
        #1;
        a = 8'($urandom);
        req_vld = 4'b0010;
        req_arg[8 +: 8] = a;
        @(posedge clk);
        #1 req_vld = '0;
        lat = -1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 10 || rsp_vld !== 4'b0010 || rsp_res !== isqrt8(a) || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_recover: lat=%0d vld=%b res=%0d id=%0d required 10/0010/%0d/1",
                     lat, rsp_vld, rsp_res, rsp_id, isqrt8(a));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef SQRT_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [7:0] a0 [8];
        int         n;
        int         bad;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req_vld = 4'b1111;
            req_arg = $urandom;
            a0[i]   = req_arg[7:0];
            @(negedge clk);
            n_checks++;
            if (req_rdy !== 4'b0001) begin
                n_fail++;
                $display("FAIL fixed_grant[%0d]: req_rdy=%b required 0001", i, req_rdy);
            end
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        n = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_vld !== 4'b0) begin
                if (n >= 8 || rsp_vld !== 4'b0001 || rsp_id !== 2'd0 || rsp_res !== isqrt8(a0[n])) bad++;
                n++;
            end
        end
        n_checks++;
        if (n != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL fixed_rsp: got %0d responses, %0d wrong, required 8/0", n, bad);
        end
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_ptr_hold();
        apply_reset();
        req_vld = 4'b0010;
        req_arg = $urandom;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_first: req_rdy=%b required 0010", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        repeat (6) @(posedge clk);
        #1 req_vld = 4'b1011;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_after_gap: req_rdy=%b required 1000", req_rdy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_wrap: req_rdy=%b required 0001", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_vld = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            req_arg = $urandom;
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d responses never arrived, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
`ifndef SQRT_ARB_FIXED_PRIO_EN
        test_round_robin();
`endif
        test_stream();
        test_reset_mid();
`ifdef SQRT_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_ptr_hold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
